// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and the arbiter state encoding for the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int MEM_ADDR_W = 24;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_port_if.sv
// One memory-controller port: request fields from the requester, data/ready/available back.
interface mem_port_if;
  import mem_port_arbiter_pkg::*;

  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_DATA_W-1:0] data;
  logic [MEM_BE_W-1:0]   byte_en;
  logic                  wr;
  logic                  rd;
  logic                  burst;
  logic [MEM_DATA_W-1:0] q;
  logic                  ready;
  logic                  available;

  // Valid/ready contract: the requester holds rd|wr and all request fields steady until its
  // final ready pulse and drops them in the cycle after; ready is a one-cycle pulse per beat.
  modport controller (
    input  addr, data, byte_en, wr, rd, burst,
    output q, ready, available
  );

  modport client (
    output addr, data, byte_en, wr, rd, burst,
    input  q, ready, available
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of req searching from last+1.
module rr_pick #(
  parameter  int NUM_CLIENTS = 3,
  localparam int IW          = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [IW-1:0]          idx,
  output logic                   valid
);
  int w_cand;

  always_comb begin
    idx    = '0;
    valid  = 1'b0;
    w_cand = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      w_cand = (int'(last) + k) % NUM_CLIENTS;
      if (!valid && req[IW'(w_cand)]) begin
        idx   = IW'(w_cand);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory controller port among NUM_CLIENTS requesters,
// serialising single and burst transactions and steering ready to the current owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int BURST_LEN   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mem_port_if.controller                 clients [NUM_CLIENTS],
  mem_port_if.client                     controller,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant_idx,
  output logic                           busy,
  output arb_state_t                     o_state
);
  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int CW = $clog2(BURST_LEN + 1);

  logic [NUM_CLIENTS-1:0] w_req;
  logic [NUM_CLIENTS-1:0] w_wr;
  logic [NUM_CLIENTS-1:0] w_burst;
  logic [MEM_ADDR_W-1:0]  w_addr [NUM_CLIENTS];
  logic [MEM_DATA_W-1:0]  w_data [NUM_CLIENTS];
  logic [MEM_BE_W-1:0]    w_be   [NUM_CLIENTS];
  logic [IW-1:0]          w_idx;
  logic                   w_valid;
  logic [CW-1:0]          w_beat_next;
  logic [CW-1:0]          w_beats_req;

  arb_state_t             r_state;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_last;
  logic [CW-1:0]          r_beat_cnt;
  logic [MEM_ADDR_W-1:0]  r_addr;
  logic [MEM_DATA_W-1:0]  r_data;
  logic [MEM_BE_W-1:0]    r_be;
  logic                   r_burst;
  logic                   r_rd_stb;
  logic                   r_wr_stb;

  // A simultaneous rd+wr request is granted as a write.
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
    assign w_req[g]   = clients[g].rd | clients[g].wr;
    assign w_wr[g]    = clients[g].wr;
    assign w_burst[g] = clients[g].burst;
    assign w_addr[g]  = clients[g].addr;
    assign w_data[g]  = clients[g].data;
    assign w_be[g]    = clients[g].byte_en;

    assign clients[g].q         = controller.q;
    assign clients[g].ready     = controller.ready & (r_state == WAIT) & (r_owner == IW'(g));
    assign clients[g].available = controller.available & ~busy;
  end

  rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr_pick (
    .req   (w_req),
    .last  (r_last),
    .idx   (w_idx),
    .valid (w_valid)
  );

  assign w_beat_next = r_beat_cnt + 1'b1;
  assign w_beats_req = r_burst ? CW'(BURST_LEN) : CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= IW'(NUM_CLIENTS - 1);
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_burst    <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_wr_stb   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid && controller.available) begin
            r_owner    <= w_idx;
            r_addr     <= w_addr[w_idx];
            r_data     <= w_data[w_idx];
            r_be       <= w_be[w_idx];
            r_burst    <= w_burst[w_idx];
            r_wr_stb   <= w_wr[w_idx];
            r_rd_stb   <= ~w_wr[w_idx];
            r_beat_cnt <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_rd_stb <= 1'b0;
          r_wr_stb <= 1'b0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (controller.ready) begin
            r_beat_cnt <= w_beat_next;
            if (w_beat_next == w_beats_req) begin
              r_last  <= r_owner;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign controller.addr    = r_addr;
  assign controller.data    = r_data;
  assign controller.byte_en = r_be;
  assign controller.burst   = r_burst;
  assign controller.rd      = r_rd_stb;
  assign controller.wr      = r_wr_stb;

  assign busy      = (r_state != IDLE);
  assign grant_idx = r_owner;
  assign o_state   = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level round-robin model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NC = 3;
  localparam int BL = 4;

  logic clk;
  logic rst_n;
  logic [1:0] grant_idx;
  logic busy;
  arb_state_t o_state;

  mem_port_if cl_if [NC] ();
  mem_port_if ctl_if ();

  // client-side drive and observe
  logic                  tb_rd    [NC];
  logic                  tb_wr    [NC];
  logic                  tb_burst [NC];
  logic [MEM_ADDR_W-1:0] tb_addr  [NC];
  logic [MEM_DATA_W-1:0] tb_data  [NC];
  logic [MEM_BE_W-1:0]   tb_be    [NC];
  logic                  c_ready  [NC];
  logic                  c_avail  [NC];
  logic [MEM_DATA_W-1:0] c_q      [NC];

  // controller-side drive and observe
  logic                  ctl_ready;
  logic                  ctl_avail;
  logic [MEM_DATA_W-1:0] ctl_q;
  logic                  ctl_rd;
  logic                  ctl_wr;
  logic                  ctl_burst;
  logic [MEM_ADDR_W-1:0] ctl_addr;
  logic [MEM_DATA_W-1:0] ctl_data;
  logic [MEM_BE_W-1:0]   ctl_be;

  for (genvar g = 0; g < NC; g++) begin : g_cl
    assign cl_if[g].rd      = tb_rd[g];
    assign cl_if[g].wr      = tb_wr[g];
    assign cl_if[g].burst   = tb_burst[g];
    assign cl_if[g].addr    = tb_addr[g];
    assign cl_if[g].data    = tb_data[g];
    assign cl_if[g].byte_en = tb_be[g];
    assign c_ready[g]       = cl_if[g].ready;
    assign c_avail[g]       = cl_if[g].available;
    assign c_q[g]           = cl_if[g].q;
  end

  assign ctl_if.ready     = ctl_ready;
  assign ctl_if.available = ctl_avail;
  assign ctl_if.q         = ctl_q;
  assign ctl_rd           = ctl_if.rd;
  assign ctl_wr           = ctl_if.wr;
  assign ctl_burst        = ctl_if.burst;
  assign ctl_addr         = ctl_if.addr;
  assign ctl_data         = ctl_if.data;
  assign ctl_be           = ctl_if.byte_en;

  mem_port_arbiter #(.NUM_CLIENTS(NC), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clients    (cl_if),
    .controller (ctl_if),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .o_state    (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: one transaction in flight, granted round-robin from the last finisher
  bit                    m_active;
  bit                    m_strobe_due;
  int                    m_owner;
  int                    m_last;
  int                    m_gidx;
  int                    m_beats_left;
  int                    m_done;
  logic                  m_wr;
  logic                  m_burst;
  logic [MEM_ADDR_W-1:0] m_addr;
  logic [MEM_DATA_W-1:0] m_data;
  logic [MEM_BE_W-1:0]   m_be;
  int                    grant_log [$];

  // stimulus knobs (percent)
  int   p_req   = 0;
  int   p_avail = 100;
  int   p_ready = 50;
  int   p_stray = 0;
  bit   auto_req [NC];
  bit   fix_q   = 1'b0;
  logic [MEM_DATA_W-1:0] q_val = '0;

  task automatic model_reset();
    m_active     = 1'b0;
    m_strobe_due = 1'b0;
    m_last       = NC - 1;
    m_gidx       = 0;
    m_owner      = 0;
    m_beats_left = 0;
    m_done       = -1;
  endtask

  function automatic bit any_req();
    bit r = 1'b0;
    for (int i = 0; i < NC; i++) r |= (tb_rd[i] | tb_wr[i]);
    return r;
  endfunction

  function automatic int log_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  // advance the model across one active edge using the inputs presented before it
  task automatic model_update();
    int  c;
    bit  found;
    m_done = -1;
    found  = 1'b0;
    if (!m_active) begin
      if (ctl_avail) begin
        for (int k = 1; k <= NC; k++) begin
          c = (m_last + k) % NC;
          if (!found && (tb_rd[c] || tb_wr[c])) begin
            found        = 1'b1;
            m_active     = 1'b1;
            m_strobe_due = 1'b1;
            m_owner      = c;
            m_gidx       = c;
            m_wr         = tb_wr[c];
            m_burst      = tb_burst[c];
            m_addr       = tb_addr[c];
            m_data       = tb_data[c];
            m_be         = tb_be[c];
            m_beats_left = tb_burst[c] ? BL : 1;
            grant_log.push_back(c);
          end
        end
      end
    end else if (m_strobe_due) begin
      m_strobe_due = 1'b0;
    end else if (ctl_ready) begin
      m_beats_left--;
      if (m_beats_left == 0) begin
        m_active = 1'b0;
        m_last   = m_owner;
        m_done   = m_owner;
      end
    end
  endtask

  task automatic check_outputs();
    arb_state_t exp_state;
    exp_state = !m_active ? IDLE : (m_strobe_due ? ISSUE : WAIT);
    check_eq("busy", busy, m_active);
    check_eq("state", 32'(o_state), 32'(exp_state));
    check_eq("ctl_rd", ctl_rd, m_strobe_due && !m_wr);
    check_eq("ctl_wr", ctl_wr, m_strobe_due && m_wr);
    if (m_strobe_due) begin
      check_eq("ctl_addr", ctl_addr, m_addr);
      check_eq("ctl_data", ctl_data, m_data);
      check_eq("ctl_be", ctl_be, m_be);
      check_eq("ctl_burst", ctl_burst, m_burst);
    end
    check_eq("grant_idx", grant_idx, m_gidx);
    for (int i = 0; i < NC; i++) begin
      check_eq($sformatf("ready_c%0d", i), c_ready[i],
               ctl_ready && m_active && !m_strobe_due && (m_owner == i));
      check_eq($sformatf("q_c%0d", i), c_q[i], ctl_q);
      check_eq($sformatf("avail_c%0d", i), c_avail[i], ctl_avail && !m_active);
    end
  endtask

  // driver tasks
  task automatic req_set(input int i, input bit rd, input bit wr, input bit burst,
                         input logic [MEM_ADDR_W-1:0] addr, input logic [MEM_DATA_W-1:0] data);
    tb_rd[i]    = rd;
    tb_wr[i]    = wr;
    tb_burst[i] = burst;
    tb_addr[i]  = addr;
    tb_data[i]  = data;
    tb_be[i]    = 2'($urandom);
  endtask

  task automatic rand_req(input int i);
    int r;
    r = $urandom_range(0, 9);
    req_set(i, r >= 4, (r < 4) || (r == 9), $urandom_range(0, 2) == 0,
            MEM_ADDR_W'($urandom), MEM_DATA_W'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (m_done >= 0) begin
      tb_rd[m_done]    = 1'b0;
      tb_wr[m_done]    = 1'b0;
      tb_burst[m_done] = 1'b0;
    end
    for (int i = 0; i < NC; i++)
      if (auto_req[i] && !(tb_rd[i] || tb_wr[i]) && i != m_done &&
          $urandom_range(0, 99) < p_req)
        rand_req(i);
    if (m_active && !m_strobe_due) ctl_ready = ($urandom_range(0, 99) < p_ready);
    else ctl_ready = !m_active && ($urandom_range(0, 99) < p_stray);
    ctl_q     = fix_q ? q_val : MEM_DATA_W'($urandom);
    ctl_avail = ($urandom_range(0, 99) < p_avail);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until_log(input int n, input int max_cycles);
    for (int c = 0; c < max_cycles && (grant_log.size() < n || m_active); c++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < NC; i++) auto_req[i] = 1'b0;
    p_avail = 100;
    p_ready = 70;
    for (int c = 0; c < 500 && (m_active || any_req()); c++) step();
    check_eq("drain_idle", busy, 0);
  endtask

  int pulses2;
  int strobes;
  int pulses_at_second;
  bit seen_second;

  initial begin
    rst_n     = 1'b1;
    ctl_ready = 1'b0;
    ctl_avail = 1'b1;
    ctl_q     = '0;
    for (int i = 0; i < NC; i++) begin
      auto_req[i] = 1'b0;
      req_set(i, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", 32'(o_state), 32'(IDLE));
    check_eq("rst_grant_idx", grant_idx, 0);
    check_eq("rst_ctl_rd", ctl_rd, 0);
    check_eq("rst_ctl_wr", ctl_wr, 0);
    check_eq("rst_ctl_addr", ctl_addr, 0);
    check_eq("rst_ctl_data", ctl_data, 0);
    for (int i = 0; i < NC; i++) check_eq("rst_ready", c_ready[i], 0);
    @(negedge clk) rst_n = 1'b1;

    // contention straight after reset
    p_ready = 70;
    for (int i = 0; i < NC; i++)
      req_set(i, 1'b1, 1'b0, 1'b0, MEM_ADDR_W'($urandom), MEM_DATA_W'($urandom));
    run_until_log(3, 100);
    check_eq("contend_0", log_at(0), 0);
    check_eq("contend_1", log_at(1), 1);
    check_eq("contend_2", log_at(2), 2);

    // clients 0 and 2 requesting back to back
    p_req = 100;
    p_avail = 80;
    p_ready = 60;
    auto_req[0] = 1'b1;
    auto_req[2] = 1'b1;
    run_until_log(11, 600);
    drain();
    for (int j = 0; j < 8; j++)
      check_eq($sformatf("alternate_%0d", j), log_at(3 + j), (j % 2 == 0) ? 0 : 2);

    // single read from client 1
    grant_log.delete();
    fix_q   = 1'b1;
    q_val   = 16'hBEEF;
    p_ready = 100;
    req_set(1, 1'b1, 1'b0, 1'b0, 24'h001234, '0);
    for (int c = 0; c < 20 && (grant_log.size() == 0 || m_active); c++) begin
      step();
      if (ctl_rd) check_eq("single_addr", ctl_addr, 24'h001234);
      if (ctl_ready && m_active && !m_strobe_due) begin
        check_eq("single_q_c1", c_q[1], 16'hBEEF);
        check_eq("single_rdy_c1", c_ready[1], 1);
        check_eq("single_rdy_c0", c_ready[0], 0);
        check_eq("single_rdy_c2", c_ready[2], 0);
      end
    end
    check_eq("single_owner", log_at(0), 1);
    check_eq("single_busy_low", busy, 0);
    fix_q = 1'b0;

    // burst from client 2 with client 0 waiting behind it
    grant_log.delete();
    p_ready = 50;
    pulses2 = 0;
    strobes = 0;
    pulses_at_second = -1;
    seen_second = 1'b0;
    req_set(2, 1'b1, 1'b0, 1'b1, MEM_ADDR_W'($urandom), '0);
    req_set(0, 1'b0, 1'b1, 1'b0, MEM_ADDR_W'($urandom), MEM_DATA_W'($urandom));
    for (int c = 0; c < 200 && (grant_log.size() < 2 || m_active); c++) begin
      step();
      if (c_ready[2]) pulses2++;
      if (ctl_rd || ctl_wr) strobes++;
      if (grant_log.size() == 2 && !seen_second) begin
        pulses_at_second = pulses2;
        seen_second = 1'b1;
      end
    end
    check_eq("burst_first_owner", log_at(0), 2);
    check_eq("burst_pulses_c2", pulses2, BL);
    check_eq("burst_strobes", strobes, 2);
    check_eq("burst_next_after_last", pulses_at_second, BL);
    drain();

    // backpressure: controller unavailable while client 0 waits
    p_avail = 0;
    step();
    strobes = 0;
    req_set(0, 1'b0, 1'b1, 1'b0, MEM_ADDR_W'($urandom), MEM_DATA_W'($urandom));
    for (int c = 0; c < 10; c++) begin
      step();
      if (ctl_rd || ctl_wr) strobes++;
    end
    check_eq("bp_no_strobe", strobes, 0);
    p_avail = 100;
    step();
    check_eq("bp_not_yet", ctl_wr, 0);
    step();
    check_eq("bp_strobe", ctl_wr, 1);
    drain();

    // stray ready pulses while idle
    p_stray = 100;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("stray_state", 32'(o_state), 32'(IDLE));
      for (int i = 0; i < NC; i++) check_eq("stray_ready", c_ready[i], 0);
    end

    // random soak
    p_stray = 10;
    p_req   = 30;
    p_avail = 85;
    p_ready = 50;
    for (int i = 0; i < NC; i++) auto_req[i] = 1'b1;
    for (int c = 0; c < 2000; c++) step();
    p_stray = 0;
    drain();

    // reset in the middle of a burst
    p_ready = 100;
    req_set(2, 1'b1, 1'b0, 1'b1, MEM_ADDR_W'($urandom), '0);
    for (int c = 0; c < 20 && !(m_active && !m_strobe_due && m_beats_left == 2); c++) step();
    #1 rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_state", 32'(o_state), 32'(IDLE));
    check_eq("mrst_ctl_rd", ctl_rd, 0);
    check_eq("mrst_ctl_wr", ctl_wr, 0);
    check_eq("mrst_ctl_addr", ctl_addr, 0);
    check_eq("mrst_grant_idx", grant_idx, 0);
    for (int i = 0; i < NC; i++) check_eq("mrst_ready", c_ready[i], 0);
    model_reset();
    ctl_ready = 1'b0;
    req_set(0, 1'b1, 1'b0, 1'b0, MEM_ADDR_W'($urandom), '0);
    req_set(1, 1'b0, 1'b1, 1'b0, MEM_ADDR_W'($urandom), MEM_DATA_W'($urandom));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    grant_log.delete();
    run_until_log(1, 50);
    check_eq("mrst_first_grant", log_at(0), 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
